// File: rtl/lsu_rmw_if.sv
// rtl/lsu_rmw_if.sv - core request/response and data-memory bus bundle for lsu_rmw
//
// Purpose: groups the core-side request/response handshake and the word-only
// data-memory port into one interface.
// Modports:
//   slave  - the load/store unit: takes req_*, mem_rd; drives req_ready, resp_*, mem_*
//   master - the environment (core + memory): the reverse directions
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata - core request
//   resp_valid/resp_rdata/resp_err                           - one-cycle response
//   mem_we/mem_a/mem_wd/mem_rd                               - word memory port

interface lsu_rmw_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - load/store unit with byte/halfword read-modify-write stores
//
// Purpose: sits between the core MEM stage and a word-only data memory with no
// byte enables. Byte/halfword loads are extracted and sign/zero extended;
// byte/halfword stores read the word, merge the lane(s), then write it back.
// Misaligned, out-of-range and illegal-width requests answer with resp_err.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - lsu_rmw_if.slave: core request/response plus memory port
//   perf_rmw_cnt, perf_err_cnt - only when LSU_PERF_CNT_EN is defined:
//          completed SB/SH writes and error responses, wrapping at 2^32
// Parameter:
//   MEM_WORDS - memory depth in words; word index >= MEM_WORDS is an error
// Configuration macro: LSU_PERF_CNT_EN

module lsu_rmw #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  lsu_rmw_if.slave    bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0] perf_rmw_cnt,
  output logic [31:0] perf_err_cnt
`endif
);

  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] merge_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  // Request legality, judged on the raw inputs at accept time.
  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = bus.req_addr[0];
      3'b010:  req_err = |bus.req_addr[1:0];
      3'b100:  req_err = bus.req_we;
      3'b101:  req_err = bus.req_we | bus.req_addr[0];
      default: req_err = 1'b1;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS_U) req_err = 1'b1;
  end

  // Load lane extraction; funct3_q[2] selects zero extension.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = bus.mem_rd[7:0];
      2'd1:    byte_sel = bus.mem_rd[15:8];
      2'd2:    byte_sel = bus.mem_rd[23:16];
      default: byte_sel = bus.mem_rd[31:24];
    endcase
    half_sel = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~funct3_q[2] & half_sel[15]}}, half_sel};
      default: load_val = bus.mem_rd;
    endcase
  end

  // Sub-word store merge: only SB (000) and SH (001) reach this path.
  always_comb begin
    merge_val = bus.mem_rd;
    if (funct3_q[0]) begin
      if (addr_q[1]) merge_val[31:16] = data_q[15:0];
      else           merge_val[15:0]  = data_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0:    merge_val[7:0]   = data_q[7:0];
        2'd1:    merge_val[15:8]  = data_q[7:0];
        2'd2:    merge_val[23:16] = data_q[7:0];
        default: merge_val[31:24] = data_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      merge_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef LSU_PERF_CNT_EN
      perf_rmw_cnt <= '0;
      perf_err_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            data_q   <= bus.req_wdata;
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            if (req_err) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state   <= RESP;
`ifdef LSU_PERF_CNT_EN
              perf_err_cnt <= perf_err_cnt + 32'd1;
`endif
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_val;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (funct3_q[1]) begin
            // SW: the write happens in this cycle via mem_we.
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= RESP;
          end else begin
            merge_q <= merge_val;
            state   <= WRITE;
          end
        end
        WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= RESP;
`ifdef LSU_PERF_CNT_EN
          perf_rmw_cnt <= perf_rmw_cnt + 32'd1;
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Control outputs are pure decodes of the registered state, so a reset
  // that lands mid-operation drops mem_we immediately.
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_we     = (state == WRITE) ||
                          ((state == ACCESS) && we_q && (funct3_q == 3'b010));
  assign bus.mem_a      = {addr_q[31:2], 2'b00};
  assign bus.mem_wd     = (state == WRITE) ? merge_q : data_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - self-checking bench for lsu_rmw with a byte-level reference model

module tb_lsu_rmw;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_rmw_if bus();

`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_rmw_cnt;
  logic [31:0] perf_err_cnt;
`endif

  lsu_rmw #(.MEM_WORDS(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LSU_PERF_CNT_EN
    ,
    .perf_rmw_cnt(perf_rmw_cnt),
    .perf_err_cnt(perf_err_cnt)
`endif
  );

  // Data memory: combinational read, synchronous write, plus a preload port.
  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  assign bus.mem_rd = mem[bus.mem_a[7:2]];
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (bus.mem_we) mem[bus.mem_a[7:2]] <= bus.mem_wd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
    int          idx;
    logic [31:0] word;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [0:63];
  int          exp_rmw = 0;
  int          exp_err = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          we_seen = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_lat = 0;
  int          last_we = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: treats memory as bytes and applies the width/extension rules directly.
  function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                 input bit [31:0] wd);
    exp_t   e;
    int     size;
    int     off;
    int     idx;
    bit     bad;
    longint v;
    size = (f3 == 3'b000 || f3 == 3'b100) ? 1 :
           (f3 == 3'b001 || f3 == 3'b101) ? 2 :
           (f3 == 3'b010) ? 4 : 0;
    bad = (size == 0) || (we && f3[2]);
    if (!bad) bad = (addr % size) != 0;
    if ((addr >> 2) >= 64) bad = 1'b1;
    e.acc = 0; e.rdata = '0; e.err = bad; e.nwe = 0; e.idx = -1; e.word = '0; e.lat = 1;
    if (bad) begin
      exp_err++;
    end else begin
      idx = int'(addr >> 2);
      off = int'(addr % 4);
      e.idx = idx;
      if (!we) begin
        v = (longint'(ref_mem[idx]) >> (8 * off)) & ((64'sd1 << (8 * size)) - 1);
        if (size < 4 && !f3[2] && v[8 * size - 1]) v = v - (64'sd1 << (8 * size));
        e.rdata = v[31:0];
        e.lat = 2;
      end else begin
        for (int b = 0; b < size; b++) ref_mem[idx][8 * (off + b) +: 8] = wd[8 * b +: 8];
        e.lat = (size == 4) ? 2 : 3;
        e.nwe = 1;
        if (size < 4) exp_rmw++;
      end
      e.word = ref_mem[idx];
    end
    return e;
  endfunction

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) we_seen++;
      if (q.size() > 0) check("busy_ready", {31'b0, bus.req_ready}, 32'd0);
      if (bus.resp_valid) begin
        if (q.size() == 0) begin
          fail("unexpected_resp");
        end else begin
          exp_t e;
          e = q.pop_front();
          check("latency", cyc - e.acc, e.lat);
          check("rdata", bus.resp_rdata, e.rdata);
          check("err", {31'b0, bus.resp_err}, {31'b0, e.err});
          check("mem_we_pulses", we_seen, e.nwe);
          if (e.idx >= 0) check("mem_word", mem[e.idx], e.word);
          last_rdata = bus.resp_rdata;
          last_err = bus.resp_err;
          last_lat = cyc - e.acc;
        end
        last_we = we_seen;
        we_seen = 0;
      end
    end
  end

  task automatic preload(input int i, input logic [31:0] v);
    @(negedge clk);
    pre_idx = 6'(i);
    pre_val = v;
    pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
    ref_mem[i] = v;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("ready_timeout");
  endtask

  task automatic op(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd);
    bit   ok;
    int   k;
    exp_t e;
    wait_ready(ok);
    if (ok) begin
      k = cyc;
      bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      e = model(we, f3, addr, wd);
      e.acc = k;
      q.push_back(e);
      bus.req_valid = 1'b0;
      bus.req_we = 1'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_addr = $urandom;
      bus.req_wdata = $urandom;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q.size() == 0 && bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("idle_timeout");
  endtask

  initial begin
    bit   ok;
    int   k1;
    int   k2;
    exp_t e;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    #12;
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);

    // Pinned expectations for the model and DUT.
    preload(4, 32'h803412F0);
    op(0, 3'b000, 32'h13, 0); wait_idle();
    check("lb_lit", last_rdata, 32'hFFFFFF80);
    op(0, 3'b100, 32'h13, 0); wait_idle();
    check("lbu_lit", last_rdata, 32'h00000080);
    op(0, 3'b001, 32'h12, 0); wait_idle();
    check("lh_lit", last_rdata, 32'hFFFF8034);
    preload(4, 32'h11223344);
    op(1, 3'b000, 32'h11, 32'h000000AB); wait_idle();
    check("sb_lit_mem", mem[4], 32'h1122AB44);
    check("sb_lit_lat", last_lat, 3);
    check("sb_lit_we", last_we, 1);
    op(1, 3'b001, 32'h11, 32'hFFFF); wait_idle();
    check("sh_mis_err", {31'b0, last_err}, 32'd1);
    check("sh_mis_lat", last_lat, 1);
    check("sh_mis_we", last_we, 0);
    check("sh_mis_mem", mem[4], 32'h1122AB44);
    op(0, 3'b010, 32'h102, 0); wait_idle();
    check("lw_mis_err", {31'b0, last_err}, 32'd1);
    check("lw_mis_rdata", last_rdata, 32'd0);
    op(0, 3'b010, 32'h100, 0); wait_idle();
    check("lw_oor_err", {31'b0, last_err}, 32'd1);
    preload(63, 32'hCAFE0163);
    op(0, 3'b010, 32'hFC, 0); wait_idle();
    check("lw_last_rdata", last_rdata, 32'hCAFE0163);
    check("lw_last_err", {31'b0, last_err}, 32'd0);

    // Reset while the SB sits in ACCESS.
    wait_ready(ok);
    bus.req_we = 1'b1; bus.req_funct3 = 3'b000; bus.req_addr = 32'h11;
    bus.req_wdata = 32'h55; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("midrst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    exp_rmw = 0;
    exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_mem", mem[4], 32'h1122AB44);
    check("midrst_we_seen", we_seen, 0);

    // Two SW with req_valid held throughout.
    wait_ready(ok);
    k1 = cyc;
    bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h0BADF00D; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    e = model(1, 3'b010, 32'h20, 32'h0BADF00D);
    e.acc = k1;
    q.push_back(e);
    bus.req_addr = 32'h24; bus.req_wdata = 32'h600DD00D;
    wait_ready(ok);
    k2 = cyc;
    @(posedge clk);
    #1;
    e = model(1, 3'b010, 32'h24, 32'h600DD00D);
    e.acc = k2;
    q.push_back(e);
    bus.req_valid = 1'b0;
    check("b2b_gap", k2 - k1, 3);
    wait_idle();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      bit [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 300));
      op(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
    end
    wait_idle();
    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);
`ifdef LSU_PERF_CNT_EN
    check("perf_rmw", perf_rmw_cnt, 32'(exp_rmw));
    check("perf_err", perf_err_cnt, 32'(exp_err));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
